pspin_her_credit_queue: RTL and testbench
=========================================

PSPIN_HER_CREDIT_QUEUE -- requirements
Module: pspin_her_credit_queue

Interface
REQ-001 SHALL have parameter C_MSGID_WIDTH, default 10, the message ID width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, the HER address and size width.
REQ-003 SHALL have parameter LEN_WIDTH, default 32, the feedback size width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, the HER buffer entries (power of 2, at least 2).
REQ-005 SHALL have parameter CREDIT_WIDTH, default 8, the in-flight counter width.
REQ-006 SHALL run on one clock with synchronous active-low reset; ports clk and rstn, both inputs, 1 bit.
REQ-007 SHALL have HER input ports s_her_valid (in, 1), s_her_ready (out, 1), s_her_msgid (in, C_MSGID_WIDTH), s_her_is_eom (in, 1), s_her_addr (in, AXI_ADDR_WIDTH), s_her_size (in, AXI_ADDR_WIDTH) and s_her_xfer_size (in, AXI_ADDR_WIDTH).
REQ-008 SHALL have HER output ports to the PsPIN wrapper: m_her_valid (out), m_her_ready (in), and m_her_msgid/is_eom/addr/size/xfer_size (out), with the same widths as the input ports.
REQ-009 SHALL have feedback input ports from PsPIN: s_feedback_valid (in, 1), s_feedback_ready (out, 1), s_feedback_her_addr (in, AXI_ADDR_WIDTH), s_feedback_her_size (in, LEN_WIDTH) and s_feedback_msgid (in, C_MSGID_WIDTH).
REQ-010 SHALL have feedback output ports to the allocator: m_feedback_valid/her_addr/her_size/msgid (out) and m_feedback_ready (in), with the same widths as the feedback inputs.
REQ-011 SHALL have configuration input conf_max_inflight (in, CREDIT_WIDTH), the maximum number of HERs outstanding at PsPIN.
REQ-012 SHALL have status outputs:
- stat_inflight (out, CREDIT_WIDTH)
- stat_fifo_level (out, $clog2(FIFO_DEPTH)+1)
- stat_eom_count (out, 32)
- stat_underflow (out, 1)

Function
REQ-013 SHALL buffer HERs in a FIFO_DEPTH-entry FIFO in arrival order; s_her_ready = (level != FIFO_DEPTH).
REQ-014 SHALL present the head entry on m_her_* the cycle after it is pushed (1-cycle minimum latency); it SHALL NOT bypass the FIFO combinationally.
REQ-015 SHALL assert m_her_valid = (level != 0) && (stat_inflight < conf_max_inflight); m_her_* SHALL remain stable while valid and not ready.
REQ-016 SHALL pop on dispatch (m_her_valid && m_her_ready) and increment stat_inflight by 1.
REQ-017 SHALL pass feedback combinationally: m_feedback_* = s_feedback_*, s_feedback_ready = m_feedback_ready.
REQ-018 SHALL decrement stat_inflight by 1 on a feedback handshake (s_feedback_valid && m_feedback_ready).
REQ-019 SHALL leave stat_inflight unchanged when a dispatch and a feedback handshake occur in the same cycle.
REQ-020 SHALL, on a feedback handshake with stat_inflight == 0 and no same-cycle dispatch, hold stat_inflight at 0 and set stat_underflow sticky until reset.
REQ-021 SHALL saturate stat_inflight at 2^CREDIT_WIDTH-1; dispatch is inherently blocked because conf_max_inflight cannot exceed that value.
REQ-022 SHALL block all dispatch when conf_max_inflight == 0; the FIFO still fills and backpressures.
REQ-023 SHALL handle a lowered conf_max_inflight below stat_inflight by holding dispatch until stat_inflight drops below it, without flushing.
REQ-024 SHALL, on simultaneous push and pop, keep the level unchanged; a push when full SHALL NOT occur because ready is low.
REQ-025 SHALL wrap read and write pointers modulo FIFO_DEPTH; the level counter SHALL distinguish full from empty.
REQ-026 SHALL increment stat_eom_count (wrapping at 2^32) on each dispatch with m_her_is_eom = 1.

Reset
REQ-027 SHALL clear, while rstn is low at a clock edge:
- level, pointers, stat_inflight, stat_eom_count and stat_underflow to 0
- m_her_valid to 0
- s_her_ready to 1 from the first cycle after reset
REQ-028 SHALL discard buffered HERs on a reset mid-operation; feedback arriving during reset SHALL be passed through but not counted.

Verification
REQ-029 Scenario: conf_max_inflight=2, push 3 HERs, m_her_ready=1 -> exactly 2 dispatched, stat_inflight=2, third held valid-low. One feedback -> third dispatched next cycle, stat_inflight stays 2.
REQ-030 Scenario: m_her_ready=0, push 8 HERs with FIFO_DEPTH=8 -> s_her_ready=0 after the 8th, stat_fifo_level=8. Release ready -> 8 HERs emerge in order with correct msgid/addr.
REQ-031 Scenario: stat_inflight=1, dispatch and feedback in the same cycle -> stat_inflight remains 1, stat_underflow=0.
REQ-032 Scenario: feedback with stat_inflight=0 -> stat_inflight=0, stat_underflow=1 and stays 1 until reset.
REQ-033 Scenario: dispatch 3 HERs with is_eom=0,1,1 -> stat_eom_count=2. Reset mid-stream with 4 buffered -> level=0, m_her_valid=0, counters=0.
REQ-034 Scenario: conf_max_inflight=0 with a full FIFO -> no dispatch for 100 cycles. Set it to 1 -> exactly one dispatch.

Source files
------------

// File: rtl/pspin_her_credit_queue.sv
// HER credit queue: buffers handler execution requests in a FIFO and releases
// them to PsPIN only while fewer than conf_max_inflight HERs are outstanding.
// Feedback from PsPIN passes straight through to the allocator and returns credit.
module pspin_her_credit_queue #(
  parameter int unsigned C_MSGID_WIDTH  = 10,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned CREDIT_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  // HER input
  input  logic                          s_her_valid,
  output logic                          s_her_ready,
  input  logic [C_MSGID_WIDTH-1:0]      s_her_msgid,
  input  logic                          s_her_is_eom,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_her_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_her_size,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_her_xfer_size,
  // HER output to PsPIN
  output logic                          m_her_valid,
  input  logic                          m_her_ready,
  output logic [C_MSGID_WIDTH-1:0]      m_her_msgid,
  output logic                          m_her_is_eom,
  output logic [AXI_ADDR_WIDTH-1:0]     m_her_addr,
  output logic [AXI_ADDR_WIDTH-1:0]     m_her_size,
  output logic [AXI_ADDR_WIDTH-1:0]     m_her_xfer_size,
  // Feedback from PsPIN
  input  logic                          s_feedback_valid,
  output logic                          s_feedback_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_feedback_her_addr,
  input  logic [LEN_WIDTH-1:0]          s_feedback_her_size,
  input  logic [C_MSGID_WIDTH-1:0]      s_feedback_msgid,
  // Feedback to allocator
  output logic                          m_feedback_valid,
  input  logic                          m_feedback_ready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_feedback_her_addr,
  output logic [LEN_WIDTH-1:0]          m_feedback_her_size,
  output logic [C_MSGID_WIDTH-1:0]      m_feedback_msgid,
  // Configuration and status
  input  logic [CREDIT_WIDTH-1:0]       conf_max_inflight,
  output logic [CREDIT_WIDTH-1:0]       stat_inflight,
  output logic [$clog2(FIFO_DEPTH):0]   stat_fifo_level,
  output logic [31:0]                   stat_eom_count,
  output logic                          stat_underflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ENT_W = C_MSGID_WIDTH + 1 + 3 * AXI_ADDR_WIDTH;
  localparam logic [LVL_W-1:0]        FULL_LVL   = LVL_W'(FIFO_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = '1;

  logic [ENT_W-1:0]        mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [CREDIT_WIDTH-1:0] inflight_q, inflight_d;
  logic [31:0]             eom_cnt_q, eom_cnt_d;
  logic                    underflow_q, underflow_d;

  logic push;
  logic dispatch;
  logic fb_hs;

  // Head is read from registered storage, so a pushed entry is visible one cycle later.
  assign {m_her_msgid, m_her_is_eom, m_her_addr, m_her_size, m_her_xfer_size} = mem_q[rd_ptr_q];

  assign s_her_ready = (level_q != FULL_LVL);
  assign m_her_valid = (level_q != '0) && (inflight_q < conf_max_inflight);

  assign push     = s_her_valid && s_her_ready;
  assign dispatch = m_her_valid && m_her_ready;
  assign fb_hs    = s_feedback_valid && m_feedback_ready;

  assign m_feedback_valid    = s_feedback_valid;
  assign m_feedback_her_addr = s_feedback_her_addr;
  assign m_feedback_her_size = s_feedback_her_size;
  assign m_feedback_msgid    = s_feedback_msgid;
  assign s_feedback_ready    = m_feedback_ready;

  assign stat_inflight   = inflight_q;
  assign stat_fifo_level = level_q;
  assign stat_eom_count  = eom_cnt_q;
  assign stat_underflow  = underflow_q;

  // Next-state for FIFO storage, pointers, level and credit/status counters.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    inflight_d  = inflight_q;
    eom_cnt_d   = eom_cnt_q;
    underflow_d = underflow_q;

    if (push) begin
      mem_d[wr_ptr_q] = {s_her_msgid, s_her_is_eom, s_her_addr, s_her_size, s_her_xfer_size};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (dispatch) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (m_her_is_eom) eom_cnt_d = eom_cnt_q + 32'd1;
    end

    case ({push, dispatch})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A dispatch and a returned credit in the same cycle cancel out.
    if (dispatch && !fb_hs) begin
      if (inflight_q != CREDIT_MAX) inflight_d = inflight_q + 1'b1;
    end else if (fb_hs && !dispatch) begin
      if (inflight_q == '0) underflow_d = 1'b1;
      else                  inflight_d  = inflight_q - 1'b1;
    end
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      inflight_q  <= '0;
      eom_cnt_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      inflight_q  <= inflight_d;
      eom_cnt_q   <= eom_cnt_d;
      underflow_q <= underflow_d;
    end
  end

  // FIFO payload storage; contents are don't-care while the level is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_pspin_her_credit_queue.sv
// Testbench for pspin_her_credit_queue: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_pspin_her_credit_queue;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [9:0]  msgid;
    logic        eom;
    logic [31:0] addr;
    logic [31:0] size;
    logic [31:0] xfer;
  } her_t;

  logic        clk;
  logic        rstn;
  logic        her_valid;
  her_t        in_her;
  logic        s_her_ready;
  logic        m_her_valid;
  logic        m_ready;
  logic [9:0]  m_msgid;
  logic        m_eom;
  logic [31:0] m_addr, m_size, m_xfer;
  logic        fb_valid, fb_s_ready, fb_m_ready;
  logic [31:0] fb_addr, fb_size;
  logic [9:0]  fb_msgid;
  logic        fbo_valid;
  logic [31:0] fbo_addr, fbo_size;
  logic [9:0]  fbo_msgid;
  logic [7:0]  conf;
  logic [7:0]  stat_inflight;
  logic [3:0]  stat_level;
  logic [31:0] stat_eom;
  logic        stat_uf;

  int total = 0;
  int bad   = 0;

  // Reference model state
  her_t        q[$];
  int          m_infl;
  logic [31:0] m_eomc;
  logic        m_uf;

  pspin_her_credit_queue #(
    .C_MSGID_WIDTH (10),
    .AXI_ADDR_WIDTH(32),
    .LEN_WIDTH     (32),
    .FIFO_DEPTH    (DEPTH),
    .CREDIT_WIDTH  (8)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .s_her_valid        (her_valid),
    .s_her_ready        (s_her_ready),
    .s_her_msgid        (in_her.msgid),
    .s_her_is_eom       (in_her.eom),
    .s_her_addr         (in_her.addr),
    .s_her_size         (in_her.size),
    .s_her_xfer_size    (in_her.xfer),
    .m_her_valid        (m_her_valid),
    .m_her_ready        (m_ready),
    .m_her_msgid        (m_msgid),
    .m_her_is_eom       (m_eom),
    .m_her_addr         (m_addr),
    .m_her_size         (m_size),
    .m_her_xfer_size    (m_xfer),
    .s_feedback_valid   (fb_valid),
    .s_feedback_ready   (fb_s_ready),
    .s_feedback_her_addr(fb_addr),
    .s_feedback_her_size(fb_size),
    .s_feedback_msgid   (fb_msgid),
    .m_feedback_valid   (fbo_valid),
    .m_feedback_ready   (fb_m_ready),
    .m_feedback_her_addr(fbo_addr),
    .m_feedback_her_size(fbo_size),
    .m_feedback_msgid   (fbo_msgid),
    .conf_max_inflight  (conf),
    .stat_inflight      (stat_inflight),
    .stat_fifo_level    (stat_level),
    .stat_eom_count     (stat_eom),
    .stat_underflow     (stat_uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic her_t rand_her();
    her_t h;
    h.msgid = 10'($urandom);
    h.eom   = 1'($urandom);
    h.addr  = $urandom;
    h.size  = $urandom;
    h.xfer  = $urandom;
    return h;
  endfunction

  // Advance one clock: update the reference model from the inputs applied this
  // cycle, then return at the next falling edge ready for new stimulus.
  task automatic step();
    bit disp, pushok, fbh;
    if (!rstn) begin
      q.delete();
      m_infl = 0;
      m_eomc = '0;
      m_uf   = 1'b0;
    end else begin
      disp   = (q.size() != 0) && (m_infl < int'(conf)) && m_ready;
      pushok = her_valid && (q.size() < DEPTH);
      fbh    = fb_valid && fb_m_ready;
      if (disp) begin
        if (q[0].eom) m_eomc = m_eomc + 32'd1;
        void'(q.pop_front());
      end
      if (pushok) q.push_back(in_her);
      if (disp && !fbh) m_infl = (m_infl == 255) ? 255 : m_infl + 1;
      else if (fbh && !disp) begin
        if (m_infl == 0) m_uf = 1'b1;
        else m_infl = m_infl - 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    her_valid  = 1'b0;
    in_her     = '0;
    m_ready    = 1'b0;
    fb_valid   = 1'b0;
    fb_m_ready = 1'b0;
    fb_addr    = '0;
    fb_size    = '0;
    fb_msgid   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    fb_valid = 1'b1;
    fb_m_ready = 1'b1;
    step();
    step();
    rstn = 1'b1;
    fb_valid = 1'b0;
    #1;
    total++; if (s_her_ready !== 1'b1) begin bad++; $display("FAIL reset_s_her_ready got=%0d exp=1", s_her_ready); end
    total++; if (m_her_valid !== 1'b0) begin bad++; $display("FAIL reset_m_her_valid got=%0d exp=0", m_her_valid); end
    total++; if (stat_inflight !== 8'd0) begin bad++; $display("FAIL reset_inflight got=%0d exp=0", stat_inflight); end
    total++; if (stat_level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", stat_level); end
    total++; if (stat_eom !== 32'd0) begin bad++; $display("FAIL reset_eom got=%0d exp=0", stat_eom); end
    total++; if (stat_uf !== 1'b0) begin bad++; $display("FAIL reset_underflow got=%0d exp=0", stat_uf); end
  endtask

  task automatic test_credit_limit();
    her_t exp[3];
    do_reset();
    conf = 8'd2;
    for (int i = 0; i < 3; i++) begin
      exp[i] = rand_her();
      in_her = exp[i];
      her_valid = 1'b1;
      step();
    end
    her_valid = 1'b0;
    #1;
    total++; if (stat_level !== 4'd3) begin bad++; $display("FAIL credit_level3 got=%0d exp=3", stat_level); end
    total++; if (m_her_valid !== 1'b1 || m_msgid !== exp[0].msgid) begin bad++; $display("FAIL credit_head got=%0d/%0h exp=1/%0h", m_her_valid, m_msgid, exp[0].msgid); end
    m_ready = 1'b1;
    step();
    #1;
    total++; if (m_msgid !== exp[1].msgid || m_addr !== exp[1].addr) begin bad++; $display("FAIL credit_second got=%0h exp=%0h", m_msgid, exp[1].msgid); end
    for (int i = 0; i < 5; i++) step();
    #1;
    total++; if (stat_inflight !== 8'd2) begin bad++; $display("FAIL credit_inflight2 got=%0d exp=2", stat_inflight); end
    total++; if (m_her_valid !== 1'b0 || stat_level !== 4'd1) begin bad++; $display("FAIL credit_held got=%0d/%0d exp=0/1", m_her_valid, stat_level); end
    fb_valid = 1'b1;
    fb_m_ready = 1'b1;
    step();
    fb_valid = 1'b0;
    #1;
    total++; if (m_her_valid !== 1'b1 || m_msgid !== exp[2].msgid) begin bad++; $display("FAIL credit_third_valid got=%0d/%0h exp=1/%0h", m_her_valid, m_msgid, exp[2].msgid); end
    step();
    #1;
    total++; if (stat_inflight !== 8'd2 || stat_level !== 4'd0) begin bad++; $display("FAIL credit_after got=%0d/%0d exp=2/0", stat_inflight, stat_level); end
    m_ready = 1'b0;
  endtask

  task automatic test_full_in_order();
    her_t exp[DEPTH];
    do_reset();
    conf = 8'd8;
    for (int i = 0; i < DEPTH; i++) begin
      exp[i] = rand_her();
      in_her = exp[i];
      her_valid = 1'b1;
      step();
    end
    her_valid = 1'b0;
    #1;
    total++; if (s_her_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0d exp=0", s_her_ready); end
    total++; if (stat_level !== 4'd8) begin bad++; $display("FAIL full_level got=%0d exp=8", stat_level); end
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      total++;
      if (m_her_valid !== 1'b1 || m_msgid !== exp[i].msgid || m_addr !== exp[i].addr || m_xfer !== exp[i].xfer) begin
        bad++; $display("FAIL full_order[%0d] got=%0d/%0h/%0h exp=1/%0h/%0h", i, m_her_valid, m_msgid, m_addr, exp[i].msgid, exp[i].addr);
      end
      step();
    end
    #1;
    total++; if (stat_level !== 4'd0 || stat_inflight !== 8'd8) begin bad++; $display("FAIL full_drained got=%0d/%0d exp=0/8", stat_level, stat_inflight); end
    m_ready = 1'b0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    conf = 8'd4;
    for (int i = 0; i < 2; i++) begin
      in_her = rand_her();
      her_valid = 1'b1;
      step();
    end
    her_valid = 1'b0;
    m_ready = 1'b1;
    step();
    #1;
    total++; if (stat_inflight !== 8'd1) begin bad++; $display("FAIL same_pre got=%0d exp=1", stat_inflight); end
    fb_valid = 1'b1;
    fb_m_ready = 1'b1;
    step();
    fb_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    total++; if (stat_inflight !== 8'd1 || stat_uf !== 1'b0 || stat_level !== 4'd0) begin bad++; $display("FAIL same_cycle got=%0d/%0d/%0d exp=1/0/0", stat_inflight, stat_uf, stat_level); end
  endtask

  task automatic test_underflow();
    do_reset();
    conf = 8'd1;
    fb_valid = 1'b1;
    fb_m_ready = 1'b1;
    step();
    fb_valid = 1'b0;
    #1;
    total++; if (stat_inflight !== 8'd0 || stat_uf !== 1'b1) begin bad++; $display("FAIL uf_set got=%0d/%0d exp=0/1", stat_inflight, stat_uf); end
    in_her = rand_her();
    her_valid = 1'b1;
    step();
    her_valid = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    #1;
    total++; if (stat_inflight !== 8'd1 || stat_uf !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%0d/%0d exp=1/1", stat_inflight, stat_uf); end
    do_reset();
    #1;
    total++; if (stat_uf !== 1'b0) begin bad++; $display("FAIL uf_cleared got=%0d exp=0", stat_uf); end
  endtask

  task automatic test_eom_and_reset();
    bit [2:0] eoms;
    do_reset();
    conf = 8'd8;
    m_ready = 1'b1;
    eoms = 3'b110;
    for (int i = 0; i < 3; i++) begin
      in_her = rand_her();
      in_her.eom = eoms[i];
      her_valid = 1'b1;
      step();
    end
    her_valid = 1'b0;
    step();
    step();
    #1;
    total++; if (stat_eom !== 32'd2 || stat_inflight !== 8'd3) begin bad++; $display("FAIL eom_count got=%0d/%0d exp=2/3", stat_eom, stat_inflight); end
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_her = rand_her();
      her_valid = 1'b1;
      step();
    end
    her_valid = 1'b0;
    #1;
    total++; if (stat_level !== 4'd4 || m_her_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%0d/%0d exp=4/1", stat_level, m_her_valid); end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    #1;
    total++;
    if (stat_level !== 4'd0 || m_her_valid !== 1'b0 || stat_inflight !== 8'd0 || stat_eom !== 32'd0 || s_her_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_post got=%0d/%0d/%0d/%0d exp=0/0/0/0", stat_level, m_her_valid, stat_inflight, stat_eom);
    end
  endtask

  task automatic test_zero_credit();
    int nd;
    do_reset();
    conf = 8'd0;
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_her = rand_her();
      her_valid = 1'b1;
      step();
    end
    her_valid = 1'b0;
    #1;
    total++; if (s_her_ready !== 1'b0 || stat_level !== 4'd8) begin bad++; $display("FAIL zero_full got=%0d/%0d exp=0/8", s_her_ready, stat_level); end
    nd = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (m_her_valid && m_ready) nd++;
      step();
    end
    total++; if (nd !== 0 || stat_level !== 4'd8) begin bad++; $display("FAIL zero_blocked got=%0d/%0d exp=0/8", nd, stat_level); end
    conf = 8'd1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (m_her_valid && m_ready) nd++;
      step();
    end
    #1;
    total++; if (nd !== 1 || stat_level !== 4'd7 || stat_inflight !== 8'd1) begin bad++; $display("FAIL zero_one got=%0d/%0d/%0d exp=1/7/1", nd, stat_level, stat_inflight); end
    m_ready = 1'b0;
  endtask

  task automatic test_feedback_pass();
    for (int i = 0; i < 4; i++) begin
      fb_valid   = 1'($urandom);
      fb_m_ready = 1'($urandom);
      fb_addr    = $urandom;
      fb_size    = $urandom;
      fb_msgid   = 10'($urandom);
      #1;
      total++;
      if (fbo_valid !== fb_valid || fbo_addr !== fb_addr || fbo_size !== fb_size || fbo_msgid !== fb_msgid || fb_s_ready !== fb_m_ready) begin
        bad++; $display("FAIL fb_pass[%0d] got=%0h/%0h rdy=%0d exp=%0h/%0h rdy=%0d", i, fbo_addr, fbo_msgid, fb_s_ready, fb_addr, fb_msgid, fb_m_ready);
      end
      fb_valid = 1'b0;
      step();
    end
    fb_m_ready = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    conf = 8'd3;
    for (int c = 0; c < 3000; c++) begin
      her_valid  = 1'($urandom_range(0, 1));
      in_her     = rand_her();
      m_ready    = ($urandom_range(0, 3) != 0);
      fb_valid   = ($urandom_range(0, 3) == 0);
      fb_m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) conf = 8'($urandom_range(0, 4));
      #1;
      total++; if (s_her_ready !== (q.size() != DEPTH)) begin bad++; $display("FAIL rnd_ready c=%0d got=%0d exp=%0d", c, s_her_ready, q.size() != DEPTH); end
      total++; if (m_her_valid !== ((q.size() != 0) && (m_infl < int'(conf)))) begin bad++; $display("FAIL rnd_valid c=%0d got=%0d", c, m_her_valid); end
      if (q.size() != 0) begin
        total++;
        if ({m_msgid, m_eom, m_addr, m_size, m_xfer} !== q[0]) begin
          bad++; $display("FAIL rnd_head c=%0d got=%0h/%0h exp=%0h/%0h", c, m_msgid, m_addr, q[0].msgid, q[0].addr);
        end
      end
      total++; if (stat_inflight !== 8'(m_infl)) begin bad++; $display("FAIL rnd_inflight c=%0d got=%0d exp=%0d", c, stat_inflight, m_infl); end
      total++; if (stat_level !== 4'(q.size())) begin bad++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, stat_level, q.size()); end
      total++; if (stat_eom !== m_eomc || stat_uf !== m_uf) begin bad++; $display("FAIL rnd_stat c=%0d got=%0d/%0d exp=%0d/%0d", c, stat_eom, stat_uf, m_eomc, m_uf); end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    conf = 8'd0;
    @(negedge clk);
    test_reset();
    test_credit_limit();
    test_full_in_order();
    test_same_cycle();
    test_underflow();
    test_eom_and_reset();
    test_zero_credit();
    test_feedback_pass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
